// File: rtl/cache_arb_pkg.sv
// cache_arb_pkg: shared types and width defaults for the
// icache/dcache to physical-memory cacheline arbiter.
package cache_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    typedef enum logic {
        I,
        D
    } side_t;

endpackage

// File: rtl/cacheline_arbiter_arb_pick.sv
// arb_pick: combinational tie-break between icache and dcache.
// Ports: req_i, req_d, last_grant in; grant (side_t) out.
// ARB_ROUND_ROBIN_EN: on a tie grant the side not in last_grant;
// otherwise the dcache always wins a tie.
module arb_pick
    import cache_arb_pkg::*;
(
    input  logic  req_i,
    input  logic  req_d,
    input  side_t last_grant,
    output side_t grant
);

`ifndef ARB_ROUND_ROBIN_EN
    logic unused_last;
    assign unused_last = (last_grant == D);
`endif

    always_comb begin
        grant = D;
        unique case (1'b1)
            (req_i & ~req_d): grant = I;
            (req_d & ~req_i): grant = D;
            (req_i & req_d): begin
`ifdef ARB_ROUND_ROBIN_EN
                grant = (last_grant == I) ? D : I;
`else
                grant = D;
`endif
            end
            default: grant = D;
        endcase
    end

endmodule

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: shares one physical-memory port between
// an icache (fill only) and a dcache (fill and writeback).
// Ports: clk, rst_n (async, active-low);
//   icache: i_pmem_read, i_pmem_address -> i_pmem_rdata, i_pmem_resp
//   dcache: d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata
//           -> d_pmem_rdata, d_pmem_resp
//   memory: pmem_read, pmem_write, pmem_address, pmem_wdata
//           <- pmem_rdata, pmem_resp (one-cycle pulse)
// Macro ARB_ROUND_ROBIN_EN selects round-robin tie-break;
// undefined gives fixed dcache priority.
module cacheline_arbiter
    import cache_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    state_t state;
    state_t state_nx;
    side_t  grant;
    side_t  last_grant;
    logic   req_i;
    logic   req_d;
    logic   start;

    assign req_i = i_pmem_read;
    assign req_d = d_pmem_read | d_pmem_write;
    assign start = (state == IDLE) & (req_i | req_d);

    arb_pick u_pick (
        .req_i      (req_i),
        .req_d      (req_d),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nx = (grant == I) ? SERVE_I : SERVE_D;
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Memory-side outputs are captured at the grant edge and held
    // until the response, whatever the requester does meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                if (grant == I) begin
                    pmem_read    <= 1'b1;
                    pmem_write   <= 1'b0;
                    pmem_address <= i_pmem_address;
                    pmem_wdata   <= '0;
                end else begin
                    // Writeback wins if both d requests are up.
                    pmem_read    <= ~d_pmem_write;
                    pmem_write   <= d_pmem_write;
                    pmem_address <= d_pmem_address;
                    pmem_wdata   <= d_pmem_write ? d_pmem_wdata : '0;
                end
            end else if ((state != IDLE) && pmem_resp) begin
                pmem_read  <= 1'b0;
                pmem_write <= 1'b0;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_grant <= I;
        else if (start)
            last_grant <= grant;
    end
`else
    assign last_grant = D;
`endif

    assign i_pmem_resp = (state == SERVE_I) & pmem_resp;
    assign d_pmem_resp = (state == SERVE_D) & pmem_resp;

    // Data is only forwarded for a completing read; a writeback
    // response carries nothing back to the dcache.
    assign i_pmem_rdata = (i_pmem_resp & pmem_read) ? pmem_rdata : '0;
    assign d_pmem_rdata = (d_pmem_resp & pmem_read) ? pmem_rdata : '0;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: directed and random transactions checked
// against a transaction-level arbitration model.
module tb_cacheline_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_pmem_read = 1'b0;
    logic [AW-1:0] i_pmem_address = '0;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [AW-1:0] d_pmem_address = '0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    int total = 0;
    int bad = 0;
    int m_last = 0;

    cacheline_arbiter #(
        .ADDR_W (AW),
        .LINE_W (LW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] got,
                       input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++)
            v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // 0 = icache, 1 = dcache
    function automatic int pick(bit ri, bit rd);
        if (ri && !rd) return 0;
        if (rd && !ri) return 1;
`ifdef ARB_ROUND_ROBIN_EN
        return (m_last == 0) ? 1 : 0;
`else
        return 1;
`endif
    endfunction

    task automatic drop(input int side);
        if (side == 0) begin
            i_pmem_read = 1'b0;
        end else begin
            d_pmem_read  = 1'b0;
            d_pmem_write = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".rd"}, LW'(pmem_read), '0);
        chk({tag, ".wr"}, LW'(pmem_write), '0);
        chk({tag, ".iresp"}, LW'(i_pmem_resp), '0);
        chk({tag, ".dresp"}, LW'(d_pmem_resp), '0);
        chk({tag, ".irdata"}, i_pmem_rdata, '0);
        chk({tag, ".drdata"}, d_pmem_rdata, '0);
    endtask

    task automatic req(input bit ri, input bit rd, input bit dw,
                       input logic [AW-1:0] ia, input logic [AW-1:0] da,
                       input logic [LW-1:0] wd);
        @(posedge clk); #1;
        i_pmem_read    = ri;
        i_pmem_address = ia;
        d_pmem_read    = rd;
        d_pmem_write   = dw;
        d_pmem_address = da;
        d_pmem_wdata   = wd;
    endtask

    task automatic wait_op(output bit got);
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            got = pmem_read || pmem_write;
        end
        chk("op_start", LW'(got), LW'(1));
    endtask

    // Serve every pending request; lat = cycles from op start to resp.
    task automatic serve(input int lat, input bit chg, input bit dmid,
                         input logic [LW-1:0] data_in);
        int side;
        bit got;
        bit wr;
        logic [AW-1:0] ea;
        logic [LW-1:0] ew;
        logic [LW-1:0] data;
        data = data_in;
        while (i_pmem_read || d_pmem_read || d_pmem_write) begin
            side = pick(i_pmem_read, d_pmem_read || d_pmem_write);
`ifdef ARB_ROUND_ROBIN_EN
            m_last = side;
`endif
            wr = (side == 1) && d_pmem_write;
            ea = (side == 1) ? d_pmem_address : i_pmem_address;
            ew = wr ? d_pmem_wdata : '0;
            wait_op(got);
            if (!got) begin
                drop(0);
                drop(1);
                return;
            end
            for (int c = 0; c < lat; c++) begin
                if (c > 0) @(negedge clk);
                chk("op_rd", LW'(pmem_read), LW'(!wr));
                chk("op_wr", LW'(pmem_write), LW'(wr));
                chk("addr", LW'(pmem_address), LW'(ea));
                chk("wdata", pmem_wdata, ew);
                chk("iresp_wait", LW'(i_pmem_resp), '0);
                chk("dresp_wait", LW'(d_pmem_resp), '0);
                chk("irdata_wait", i_pmem_rdata, '0);
                chk("drdata_wait", d_pmem_rdata, '0);
                @(posedge clk); #1;
                pmem_rdata = rnd_line();
                if (c == 0 && chg) i_pmem_address = i_pmem_address ^ 32'h0000_FFF0;
                if (c == 0 && dmid) drop(side);
            end
            pmem_resp  = 1'b1;
            pmem_rdata = data;
            @(negedge clk);
            chk("iresp", LW'(i_pmem_resp), LW'(side == 0));
            chk("dresp", LW'(d_pmem_resp), LW'(side == 1));
            chk("irdata", i_pmem_rdata, (side == 0) ? data : '0);
            chk("drdata", d_pmem_rdata, (side == 1 && !wr) ? data : '0);
            @(posedge clk); #1;
            pmem_resp  = 1'b0;
            pmem_rdata = rnd_line();
            drop(side);
            data = rnd_line();
            @(negedge clk);
            check_idle("post");
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        m_last = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [LW-1:0] aa;
        logic [LW-1:0] ff;
        bit got;
        aa = {8{32'hAAAA_AAAA}};
        ff = {8{32'h5555_5555}};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd", LW'(pmem_read), '0);
        chk("rst_wr", LW'(pmem_write), '0);
        chk("rst_addr", LW'(pmem_address), '0);
        chk("rst_wdata", pmem_wdata, '0);
        check_idle("rst");
        rst_n = 1'b1;

        req(1, 0, 0, 32'h0000_1000, '0, '0);
        serve(3, 0, 0, aa);

        req(0, 0, 1, '0, 32'h0000_2040, ff);
        serve(4, 0, 0, rnd_line());

        do_reset();
        req(1, 1, 0, 32'h0000_3000, 32'h0000_4000, '0);
        serve(2, 0, 0, rnd_line());
        req(0, 0, 1, '0, 32'h0000_4400, rnd_line());
        serve(1, 0, 0, rnd_line());
        req(1, 1, 0, 32'h0000_5000, 32'h0000_6000, '0);
        serve(2, 0, 0, rnd_line());

        req(0, 1, 1, '0, 32'h0000_7000, rnd_line());
        serve(2, 0, 0, rnd_line());
        req(1, 0, 0, 32'h0000_8000, '0, '0);
        serve(3, 1, 0, rnd_line());
        req(0, 1, 0, '0, 32'h0000_9000, '0);
        serve(3, 0, 1, rnd_line());

        req(1, 0, 0, 32'h0000_A000, '0, '0);
        wait_op(got);
        @(posedge clk); #1;
        rst_n = 1'b0;
        m_last = 0;
        #1;
        chk("rst_mid_rd", LW'(pmem_read), '0);
        chk("rst_mid_addr", LW'(pmem_address), '0);
        i_pmem_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pmem_resp  = 1'b1;
        pmem_rdata = aa;
        @(negedge clk);
        chk("stale_iresp", LW'(i_pmem_resp), '0);
        chk("stale_irdata", i_pmem_rdata, '0);
        chk("stale_rd", LW'(pmem_read), '0);
        @(posedge clk); #1;
        pmem_resp = 1'b0;
        @(negedge clk);
        check_idle("stale_after");

        for (int t = 0; t < 40; t++) begin
            bit ri;
            bit rd;
            bit dw;
            ri = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            if (!ri && !rd && !dw) ri = 1'b1;
            req(ri, rd, dw, $urandom, $urandom, rnd_line());
            serve(int'($urandom_range(1, 5)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0),
                  rnd_line());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
